// File: rtl/act_skew_feeder.sv
// act_skew_feeder: accepts one activation row per cycle and emits it diagonally skewed (lane k delayed k cycles) for sys_arr.
// Defining ACT_SKEW_STALL_EN adds an out_stall input that freezes the whole feeder.
module act_skew_feeder #(
    parameter int ACT_WIDTH    = 8,
    parameter int SYS_ARR_SIZE = 8,
    parameter int CNT_WIDTH    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              in_valid,
    output logic                              in_ready,
    input  logic [ACT_WIDTH*SYS_ARR_SIZE-1:0] in_data,
    input  logic                              in_last,
    output logic [ACT_WIDTH*SYS_ARR_SIZE-1:0] act_data_out,
    output logic [SYS_ARR_SIZE-1:0]           lane_valid,
    output logic                              tile_done,
    output logic                              busy,
    output logic [CNT_WIDTH-1:0]              row_count
`ifdef ACT_SKEW_STALL_EN
    ,
    input  logic                              out_stall
`endif
);
    localparam int N  = SYS_ARR_SIZE;
    localparam int DW = $clog2(N);
    typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;
    state_t state, state_nx;
    logic [DW-1:0] drain_cnt;
    logic stall, acc, drain_end;
`ifdef ACT_SKEW_STALL_EN
    assign stall = out_stall;
`else
    assign stall = 1'b0;
`endif
    assign acc       = in_valid && in_ready;
    assign drain_end = state == DRAIN && drain_cnt == DW'(N - 2);
    always_ff @(posedge clk)
        if (reset) state <= IDLE;
        else if (!stall) state <= state_nx;
    always_comb begin
        state_nx = state;
        if (acc) state_nx = in_last ? DRAIN : STREAM;
        else if (drain_end) state_nx = IDLE;
    end
    always_comb begin
        in_ready = state != DRAIN && !stall;
        busy     = state != IDLE || |lane_valid;
    end
    // A row accepted in the tile_done cycle starts the next tile's count at 1.
    always_ff @(posedge clk)
        if (reset) begin
            drain_cnt <= '0;
            tile_done <= 1'b0;
            row_count <= '0;
        end else if (!stall) begin
            drain_cnt <= state == DRAIN ? drain_cnt + 1'b1 : '0;
            tile_done <= drain_end;
            row_count <= tile_done ? CNT_WIDTH'(acc) :
                         (acc && ~&row_count) ? row_count + 1'b1 : row_count;
        end
    for (genvar k = 0; k < N; k++) begin : g_lane
        logic [ACT_WIDTH-1:0] d [k+1];
        logic [k:0]           v;
        always_ff @(posedge clk)
            if (reset) begin
                v <= '0;
                for (int i = 0; i <= k; i++) d[i] <= '0;
            end else if (!stall) begin
                v    <= (v << 1) | (k+1)'(acc);
                d[0] <= acc ? in_data[ACT_WIDTH*k +: ACT_WIDTH] : '0;
                for (int i = 1; i <= k; i++) d[i] <= d[i-1];
            end
        assign act_data_out[ACT_WIDTH*k +: ACT_WIDTH] = d[k];
        assign lane_valid[k] = v[k];
    end
endmodule

// File: tb/tb_act_skew_feeder.sv
// tb_act_skew_feeder: scoreboard bench for act_skew_feeder; expected lane values are queued per accepted row and retired per cycle.
module tb_act_skew_feeder;
    localparam int N = 8, W = 8;
    logic clk = 0, reset = 1, in_valid = 0, in_last = 0;
    logic [W*N-1:0] in_data = '0;
    logic in_ready, tile_done, busy;
    logic [W*N-1:0] act_data_out;
    logic [N-1:0] lane_valid;
    logic [15:0] row_count;
`ifdef ACT_SKEW_STALL_EN
    logic out_stall = 0;
`endif
    always #5 clk = ~clk;

    act_skew_feeder dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .in_last(in_last), .act_data_out(act_data_out),
        .lane_valid(lane_valid), .tile_done(tile_done), .busy(busy), .row_count(row_count)
`ifdef ACT_SKEW_STALL_EN
        , .out_stall(out_stall)
`endif
    );

    typedef struct {int cyc; int lane; logic [W-1:0] v;} ent_t;
    ent_t sb[$];
    int edges = 0, done_cyc = -1, drain_end = 0, n_checks = 0, n_fail = 0;
    bit streaming = 0;
    logic [15:0] rc = 0;
    logic [W*N-1:0] row_a = {8'd7, 8'd7, 8'd9, 8'd8, 8'd3, 8'd2, 8'd1, 8'd4};
    logic [W*N-1:0] row_b = {8'd5, 8'd2, 8'd4, 8'd1, 8'd3, 8'd2, 8'd1, 8'd8};

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at edge %0d", tag, got, exp, edges);
        end
    endtask

    task automatic check_outputs();
        logic [W*N-1:0] ed = '0;
        logic [N-1:0] ev = '0;
        bit rdy;
        for (int i = 0; i < sb.size();) begin
            if (sb[i].cyc == edges) begin
                ed[W*sb[i].lane +: W] = sb[i].v;
                ev[sb[i].lane] = 1'b1;
                sb.delete(i);
            end else i++;
        end
        rdy = edges >= drain_end;
        check("act_data_out", act_data_out, ed);
        check("lane_valid", lane_valid, ev);
        check("tile_done", tile_done, edges == done_cyc);
        check("in_ready", in_ready, rdy);
        check("busy", busy, streaming || !rdy || |ev);
        check("row_count", row_count, rc);
    endtask

    task automatic step(input bit val, input logic [W*N-1:0] data, input bit last);
        bit acc;
        ent_t e;
        in_valid = val;
        in_data = data;
        in_last = last;
        acc = val && edges >= drain_end;
        @(posedge clk);
        edges++;
        if (edges - 1 == done_cyc) rc = acc ? 16'd1 : 16'd0;
        else if (acc && rc != 16'hffff) rc++;
        if (acc) begin
            for (int k = 0; k < N; k++) begin
                e.cyc = edges + k;
                e.lane = k;
                e.v = data[W*k +: W];
                sb.push_back(e);
            end
            streaming = !last;
            if (last) begin
                done_cyc = edges + N - 1;
                drain_end = edges + N - 1;
            end
        end
        @(negedge clk);
        check_outputs();
    endtask

    task automatic do_reset(input bit val);
        reset = 1;
        in_valid = val;
        in_data = '1;
        in_last = 0;
        @(posedge clk);
        edges++;
        sb.delete();
        done_cyc = -1;
        drain_end = 0;
        streaming = 0;
        rc = 0;
        @(negedge clk);
        reset = 0;
        check_outputs();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, '0, 0);
    endtask

    initial begin
        do_reset(1);
        step(1, row_a, 1);
        idle(10);
        step(1, row_a, 0);
        step(1, row_b, 1);
        idle(10);
        for (int i = 0; i < 9; i++) begin
            if (i == 3) step(0, '0, 0);
            else step(1, {$urandom(), $urandom()}, i == 8);
        end
        idle(10);
        step(1, {$urandom(), $urandom()}, 0);
        step(1, {$urandom(), $urandom()}, 1);
        for (int i = 0; i < N + 2; i++) step(1, {$urandom(), $urandom()}, 0);
        step(1, {$urandom(), $urandom()}, 1);
        idle(10);
        for (int i = 0; i < 3; i++) step(1, {$urandom(), $urandom()}, 0);
        do_reset(1);
        idle(4);
        for (int i = 0; i < 80; i++)
            step($urandom_range(0, 3) != 0, {$urandom(), $urandom()}, $urandom_range(0, 5) == 0);
        idle(12);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
